// File: rtl/trace_pkg.sv
// Shared types and elaboration helpers for the triggered trace capture buffer.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } trace_state_t;

    localparam int TRACE_WIDTH  = 64;
    localparam int TRACE_DEPTH  = 1024;
    localparam int TRACE_OWIDTH = 32;

    function automatic int beats_of(input int width, input int owidth);
        return width / owidth;
    endfunction

    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    localparam int BEATS  = beats_of(TRACE_WIDTH, TRACE_OWIDTH);
    localparam int BEAT_W = beat_idx_w(BEATS);

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one read port, registered read data.
module bram_sdp #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // No reset on the array or read register so this maps onto a block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_trigger_buf.sv
// Triggered circular trace buffer: change-filtered capture, post-trigger freeze,
// and oldest-first drain through a narrow beat-serialised dequeue port.
module trace_trigger_buf
    import trace_pkg::*;
#(
    parameter int WIDTH  = TRACE_WIDTH,
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int OWIDTH = TRACE_OWIDTH
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         data,
    input  logic [WIDTH-1:0]         change_mask,
    input  logic [WIDTH-1:0]         trig_mask,
    input  logic [WIDTH-1:0]         trig_value,
    input  logic [$clog2(DEPTH)-1:0] post_count,
    input  logic                     arm__ENA,
    output logic                     arm__RDY,
    input  logic                     clear__ENA,
    output logic                     clear__RDY,
    output logic [OWIDTH-1:0]        out_first,
    output logic                     out_first__RDY,
    input  logic                     out_deq__ENA,
    output logic                     out_deq__RDY,
    output logic                     out_last,
    output logic                     triggered,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW     = $clog2(DEPTH);
    localparam int NBEATS = beats_of(WIDTH, OWIDTH);
    localparam int BW     = beat_idx_w(NBEATS);

    localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] MAX_POST  = AW'(DEPTH - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    if (WIDTH % OWIDTH != 0) begin : g_bad_width
        $error("trace_trigger_buf: WIDTH must be a multiple of OWIDTH");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("trace_trigger_buf: DEPTH must be a power of two");
    end

    trace_state_t      state_q, state_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic [AW:0]       widx_q, widx_d;
    logic [AW-1:0]     postcnt_q, postcnt_d;
    logic              triggered_q, triggered_d;
    logic              first_q, first_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic              req_q, req_d;
    logic              dv_q, dv_d;
    logic              valid_q, valid_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [WIDTH-1:0]  word_q, word_d;

    logic              wr_en;
    logic [WIDTH-1:0]  rd_data;
    logic              changed;
    logic              trig_hit;
    logic [AW-1:0]     post_clamp;
    logic              last_word;
    logic              do_store;
    logic              enter_drain;

    logic [NBEATS-1:0][OWIDTH-1:0] word_beats;

    assign changed    = first_q || ((data & change_mask) != (last_q & change_mask));
    assign trig_hit   = enable && ((data & trig_mask) == trig_value);
    assign post_clamp = (post_count > MAX_POST) ? MAX_POST : post_count;
    assign last_word  = (widx_q == (fill_q - 1'b1));

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        fill_d      = fill_q;
        widx_d      = widx_q;
        postcnt_d   = postcnt_q;
        triggered_d = triggered_q;
        first_d     = first_q;
        last_d      = last_q;
        req_d       = 1'b0;
        dv_d        = req_q;
        valid_d     = valid_q;
        beat_d      = beat_q;
        word_d      = word_q;
        wr_en       = 1'b0;
        do_store    = 1'b0;
        enter_drain = 1'b0;

        if (dv_q) begin
            word_d  = rd_data;
            valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (arm__ENA) begin
                    fill_d      = '0;
                    wptr_d      = '0;
                    triggered_d = 1'b0;
                    first_d     = 1'b1;
                    state_d     = PRE;
                end
            end
            PRE: begin
                do_store = enable && (changed || trig_hit);
                if (trig_hit) begin
                    triggered_d = 1'b1;
                    postcnt_d   = post_clamp;
                    if (post_clamp == '0) begin
                        enter_drain = 1'b1;
                    end else begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                do_store = enable && changed;
                if (do_store) begin
                    postcnt_d = postcnt_q - 1'b1;
                    if (postcnt_q == AW'(1)) begin
                        enter_drain = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && out_deq__ENA) begin
                    if (beat_q == LAST_BEAT) begin
                        valid_d = 1'b0;
                        beat_d  = '0;
                        if (last_word) begin
                            fill_d  = '0;
                            state_d = IDLE;
                        end else begin
                            rptr_d = rptr_q + 1'b1;
                            widx_d = widx_q + 1'b1;
                            req_d  = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_store) begin
            wr_en   = 1'b1;
            wptr_d  = wptr_q + 1'b1;
            last_d  = data;
            first_d = 1'b0;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        // The oldest entry sits fill words behind the write pointer; fill==DEPTH wraps to wptr.
        if (enter_drain) begin
            state_d = DRAIN;
            rptr_d  = wptr_d - fill_d[AW-1:0];
            widx_d  = '0;
            beat_d  = '0;
            req_d   = 1'b1;
        end

        if (clear__ENA) begin
            state_d     = IDLE;
            fill_d      = '0;
            wptr_d      = '0;
            triggered_d = 1'b0;
            postcnt_d   = '0;
            valid_d     = 1'b0;
            req_d       = 1'b0;
            dv_d        = 1'b0;
            beat_d      = '0;
            wr_en       = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            widx_q      <= '0;
            postcnt_q   <= '0;
            triggered_q <= 1'b0;
            first_q     <= 1'b1;
            last_q      <= '0;
            req_q       <= 1'b0;
            dv_q        <= 1'b0;
            valid_q     <= 1'b0;
            beat_q      <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            widx_q      <= widx_d;
            postcnt_q   <= postcnt_d;
            triggered_q <= triggered_d;
            first_q     <= first_d;
            last_q      <= last_d;
            req_q       <= req_d;
            dv_q        <= dv_d;
            valid_q     <= valid_d;
            beat_q      <= beat_d;
            word_q      <= word_d;
        end
    end

    bram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bram (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (wptr_q),
        .wr_data (data),
        .rd_en   (req_q),
        .rd_addr (rptr_q),
        .rd_data (rd_data)
    );

    assign word_beats     = word_q;
    assign out_first      = word_beats[beat_q];
    assign out_first__RDY = valid_q;
    assign out_deq__RDY   = valid_q;
    assign out_last       = valid_q && (beat_q == LAST_BEAT) && last_word;
    assign arm__RDY       = (state_q == IDLE);
    assign clear__RDY     = 1'b1;
    assign triggered      = triggered_q;
    assign fill           = fill_q;

endmodule

// File: tb/tb_trace_trigger_buf.sv
// Directed scoreboard bench for trace_trigger_buf at DEPTH=8, 64-bit samples, 32-bit beats.
module tb_trace_trigger_buf;

    localparam int WIDTH  = 64;
    localparam int DEPTH  = 8;
    localparam int OWIDTH = 32;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        logic [OWIDTH-1:0] d;
        logic              last;
    } beat_t;

    logic              CLK;
    logic              nRST;
    logic              enable;
    logic [WIDTH-1:0]  data;
    logic [WIDTH-1:0]  change_mask;
    logic [WIDTH-1:0]  trig_mask;
    logic [WIDTH-1:0]  trig_value;
    logic [AW-1:0]     post_count;
    logic              arm__ENA;
    logic              arm__RDY;
    logic              clear__ENA;
    logic              clear__RDY;
    logic [OWIDTH-1:0] out_first;
    logic              out_first__RDY;
    logic              out_deq__ENA;
    logic              out_deq__RDY;
    logic              out_last;
    logic              triggered;
    logic [AW:0]       fill;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] word_q [$];
    beat_t            beat_q [$];

    trace_trigger_buf #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .OWIDTH (OWIDTH)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .enable         (enable),
        .data           (data),
        .change_mask    (change_mask),
        .trig_mask      (trig_mask),
        .trig_value     (trig_value),
        .post_count     (post_count),
        .arm__ENA       (arm__ENA),
        .arm__RDY       (arm__RDY),
        .clear__ENA     (clear__ENA),
        .clear__RDY     (clear__RDY),
        .out_first      (out_first),
        .out_first__RDY (out_first__RDY),
        .out_deq__ENA   (out_deq__ENA),
        .out_deq__RDY   (out_deq__RDY),
        .out_last       (out_last),
        .triggered      (triggered),
        .fill           (fill)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (nRST && out_deq__ENA && !out_deq__RDY) begin
            n_err++;
            $error("[TB] FAIL deq_protocol: out_deq__RDY %0b while out_deq__ENA, expected 1", out_deq__RDY);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fill"}, fill, 0);
        check({tag, "_triggered"}, triggered, 0);
        check({tag, "_out_rdy"}, out_first__RDY, 0);
        check({tag, "_out_first"}, out_first, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_arm_rdy"}, arm__RDY, 1);
        check({tag, "_clear_rdy"}, clear__RDY, 1);
    endtask

    task automatic arm_capture(input logic [WIDTH-1:0] cmask, input logic [WIDTH-1:0] tmask,
                               input logic [WIDTH-1:0] tval, input logic [AW-1:0] pc);
        change_mask = cmask;
        trig_mask   = tmask;
        trig_value  = tval;
        post_count  = pc;
        arm__ENA    = 1'b1;
        word_q.delete();
        beat_q.delete();
        @(negedge CLK);
        arm__ENA = 1'b0;
        check("arm_busy", arm__RDY, 0);
        check("arm_fill", fill, 0);
    endtask

    // Push the sample onto the scoreboard when it should land in the window.
    task automatic apply_stimulus(input logic [WIDTH-1:0] d, input bit expect_store);
        data   = d;
        enable = 1'b1;
        @(negedge CLK);
        enable = 1'b0;
        if (expect_store) begin
            word_q.push_back(d);
            if (word_q.size() > DEPTH) void'(word_q.pop_front());
        end
    endtask

    task automatic load_beats();
        beat_t b;
        foreach (word_q[i]) begin
            b.d    = word_q[i][OWIDTH-1:0];
            b.last = 1'b0;
            beat_q.push_back(b);
            b.d    = word_q[i][WIDTH-1:OWIDTH];
            b.last = (i == word_q.size() - 1);
            beat_q.push_back(b);
        end
        word_q.delete();
    endtask

    task automatic check_output(input string tag, input int max_beats);
        int    waited;
        int    taken;
        bit    boundary;
        beat_t b;
        taken    = 0;
        boundary = 1'b0;
        while (beat_q.size() > 0 && taken < max_beats) begin
            waited = 0;
            while (!out_first__RDY && waited < 16) begin
                @(negedge CLK);
                waited++;
            end
            if (!out_first__RDY) begin
                n_vec++;
                n_err++;
                $error("[TB] FAIL %s_timeout: out_first__RDY %0b after %0d cycles, expected 1", tag, out_first__RDY, waited);
                beat_q.delete();
                return;
            end
            if (taken > 0) check({tag, "_gap"}, waited, boundary ? 2 : 0);
            b = beat_q.pop_front();
            check({tag, "_beat"}, out_first, b.d);
            check({tag, "_last"}, out_last, b.last);
            boundary = (taken % 2) == 1;
            taken++;
            out_deq__ENA = 1'b1;
            @(negedge CLK);
            out_deq__ENA = 1'b0;
        end
    endtask

    task automatic check_idle_after_drain(input string tag);
        check({tag, "_idle"}, arm__RDY, 1);
        check({tag, "_fill0"}, fill, 0);
        check({tag, "_rdy0"}, out_first__RDY, 0);
    endtask

    initial begin
        nRST         = 1'b0;
        enable       = 1'b0;
        data         = '0;
        change_mask  = '1;
        trig_mask    = '1;
        trig_value   = '0;
        post_count   = '0;
        arm__ENA     = 1'b0;
        clear__ENA   = 1'b0;
        out_deq__ENA = 1'b0;

        #2;
        check_reset_outputs("reset");
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        $display("[TB] post_count=3 trigger on 5");
        arm_capture('1, '1, 64'd5, 3'd3);
        for (int i = 1; i <= 10; i++) apply_stimulus(64'(i), i <= 8);
        check("t1_fill", fill, 8);
        check("t1_trig", triggered, 1);
        load_beats();
        check_output("t1", 100);
        check_idle_after_drain("t1");

        $display("[TB] change filter");
        arm_capture(64'hFF, '1, 64'h201, 3'd0);
        apply_stimulus(64'h100, 1'b1);
        apply_stimulus(64'h101, 1'b1);
        apply_stimulus(64'h201, 1'b1);
        apply_stimulus(64'h201, 1'b0);
        check("t2_fill", fill, 3);
        load_beats();
        check_output("t2", 100);
        check_idle_after_drain("t2");

        $display("[TB] wrap");
        arm_capture('1, '1, 64'd21, 3'd0);
        for (int i = 1; i <= 21; i++) apply_stimulus(64'(i), 1'b1);
        check("t3_fill", fill, 8);
        check("t3_first", word_q[0], 14);
        load_beats();
        check_output("t3", 100);
        check_idle_after_drain("t3");

        $display("[TB] post_count clamp");
        arm_capture('1, '1, 64'd1, 3'd7);
        for (int i = 1; i <= 11; i++) apply_stimulus(64'(i), i <= 8);
        check("t4_fill", fill, 8);
        load_beats();
        check_output("t4", 100);
        check_idle_after_drain("t4");

        $display("[TB] clear mid-drain");
        arm_capture('1, '1, 64'h3333_0003, 3'd0);
        apply_stimulus(64'hAAAA_0001_1111_0001, 1'b1);
        apply_stimulus(64'hAAAA_0002_2222_0002, 1'b1);
        apply_stimulus(64'h3333_0003, 1'b1);
        check("t5_fill", fill, 3);
        load_beats();
        check_output("t5", 3);
        clear__ENA = 1'b1;
        @(negedge CLK);
        clear__ENA = 1'b0;
        beat_q.delete();
        check("t5_rdy", out_first__RDY, 0);
        check("t5_fill0", fill, 0);
        check("t5_arm_rdy", arm__RDY, 1);
        check("t5_trig0", triggered, 0);

        $display("[TB] reset mid-POST");
        arm_capture('1, '1, 64'd2, 3'd5);
        apply_stimulus(64'd1, 1'b1);
        apply_stimulus(64'd2, 1'b1);
        apply_stimulus(64'd3, 1'b1);
        check("t6_post_busy", arm__RDY, 0);
        check("t6_post_trig", triggered, 1);
        check("t6_post_fill", fill, 3);
        #2;
        nRST = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        arm_capture('1, '1, 64'hB, 3'd0);
        apply_stimulus(64'hA, 1'b1);
        apply_stimulus(64'hB, 1'b1);
        check("t6_refill", fill, 2);
        load_beats();
        check_output("t6", 100);
        check_idle_after_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
